// File: rtl/vec_out_stream.sv
// vec_out_stream
//   Captures an N-element vector plus a runtime length in one cycle, then
//   streams the elements out in index order (element 0 first), one element
//   per accepted valid/ready handshake. Lengths above N are clamped to N.
//   The block supports backpressure, a last marker, flush, and a done pulse.
//
// Optional feature:
//   VEC_OUT_STREAM_IDX_EN - when defined, adds the out_idx output. out_idx
//   holds the index of the element on out_data while out_valid=1, and 0
//   otherwise.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in         vector to send, in[N-1:0]
//   in_len     number of valid elements in `in` (clamped to N)
//   load       capture request, honoured only while busy=0
//   flush      abort the current stream (wins over load)
//   busy       a vector is held and not yet fully sent
//   out_data   current element (registered)
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data this cycle
//   out_last   high with the final element of a vector
//   done       one-cycle pulse after the final transfer
//   out_idx    (VEC_OUT_STREAM_IDX_EN only) index of the element on out_data
module vec_out_stream #(
  parameter int BITS     = 8,
  parameter int N        = 8,
  parameter int LEN_BITS = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     in [N-1:0],
  input  logic [LEN_BITS-1:0] in_len,
  input  logic                load,
  input  logic                flush,
  output logic                busy,
  output logic [BITS-1:0]     out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                done
`ifdef VEC_OUT_STREAM_IDX_EN
  ,
  output logic [LEN_BITS-1:0] out_idx
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  logic [BITS-1:0]     r_buf [N-1:0];
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] r_idx;

  logic [LEN_BITS-1:0] w_len;
  logic [LEN_BITS-1:0] w_idx_nxt;
  logic                w_at_last;

  assign w_len     = (in_len > LEN_BITS'(N)) ? LEN_BITS'(N) : in_len;
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_at_last = (r_idx == r_len - 1'b1);

`ifdef VEC_OUT_STREAM_IDX_EN
  // r_idx is forced back to 0 whenever the stream ends, so it reads 0 when idle
  assign out_idx = r_idx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!flush && load) begin
            r_buf <= in;
            r_len <= w_len;
            r_idx <= '0;
            if (w_len == '0) begin
              done <= 1'b1;
            end else begin
              r_state   <= SEND;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= in[0];
              out_last  <= (w_len == LEN_BITS'(1));
            end
          end
        end
        SEND: begin
          if (flush) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (w_at_last) begin
              r_state   <= IDLE;
              r_idx     <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              r_idx    <= w_idx_nxt;
              out_data <= r_buf[w_idx_nxt[IW-1:0]];
              out_last <= (w_idx_nxt == r_len - 1'b1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vec_out_stream.md
Name: vec_out_stream

Overview:
- Parametrised successor to the vector output buffer.
- Captures an N-element vector plus a runtime length in one cycle, then streams the elements out in index order (element 0 first), one per accepted valid/ready handshake.
- Sits between the vector compute datapath and the host-facing serial/AXI-Stream-style output. Adds backpressure, a last marker, flush and clamped length handling.

Parameters:
- BITS, 8, element width in bits.
- N, 8, maximum vector depth in elements; N >= 1.
- LEN_BITS, $clog2(N+1), width of the length and index counters.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- in  input  [BITS-1:0] x N (unpacked, in[N-1:0])  vector to send.
- in_len  input  LEN_BITS  number of valid elements in `in`.
- load  input  1  capture request; honoured only while busy=0.
- flush  input  1  abort the current stream.
- busy  output  1  high while a vector is held and not yet fully sent.
- out_data  output  BITS  current element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data this cycle.
- out_last  output  1  high with the final element of a vector.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state IDLE, busy=0, out_valid=0, out_last=0, done=0, out_data=0, index=0, internal buffer cleared to 0.
- Reset has highest priority at any time, including mid-stream. It drops the vector and produces no done pulse.
- States are IDLE and SEND.
- IDLE, load=1:
  - Register all N elements of `in`.
  - Register len = min(in_len, N). Values of in_len above N are clamped to N.
  - If len=0: stay in IDLE, pulse done next cycle, never assert out_valid.
  - Otherwise go to SEND with index=0.
- Latency: load sampled at edge k gives out_valid=1, out_data=in[0], busy=1 from edge k onward, i.e. visible in the cycle after load.
- load while busy=1 is ignored. The buffer is not disturbed.
- SEND transfer:
  - A transfer occurs on an edge where out_valid && out_ready.
  - out_data, out_last and out_valid hold stable while out_valid && !out_ready.
  - out_ready may be held high permanently, giving one element per cycle.
- SEND advance: on a transfer with index < len-1, increment index and present the next element on the following cycle.
- out_last = out_valid && (index == len-1).
- Final transfer (index == len-1):
  - Next state IDLE; out_valid=0, out_last=0, busy=0.
  - done=1 for exactly the one cycle after that edge.
- In the cycle where done=1, busy is already 0, so a load is accepted and gives back-to-back vectors with a one-cycle bubble.
- flush=1 in SEND:
  - Next state IDLE, out_valid=0, no done pulse.
  - A transfer coincident with flush is still counted by the sink, but no further elements are sent.
  - flush in IDLE is a no-op.
  - flush and load together in IDLE: flush wins and load is ignored.
- Priority order: rst_n > flush > load/transfer.
- out_data is registered from the buffer. There is no combinational path from `in` to out_data.

Optional Feature:
- Macro: VEC_OUT_STREAM_IDX_EN.
- Defined: adds output port out_idx [LEN_BITS-1:0] equal to the index of the element on out_data. It is valid while out_valid=1 and reads 0 otherwise, including after reset.
- Undefined: the port is absent and the behaviour is otherwise identical.

Test Plan:
- Basic stream: in={0x55,0x33,0x0F,0,...}, in_len=3, load at cycle 3, out_ready=1. Expect out_data 0x55, 0x33, 0x0F on consecutive cycles; out_last only with 0x0F; done pulse on the next cycle; busy back to 0.
- Backpressure: same vector with out_ready toggling 1,0,0,1,0,1. Expect each element held stable while stalled, exactly 3 transfers, no duplication or loss, and done after the 0x0F transfer.
- Boundaries:
  - in_len=0: done pulse one cycle after load, out_valid never high.
  - in_len=8 (N): all 8 elements sent.
  - in_len=12: clamped, exactly 8 elements sent, out_last on in[7].
- Load while busy: second load with a different vector mid-stream is ignored; the original 3 elements are sent unchanged. A load during the done cycle starts the new vector immediately.
- Flush/reset mid-stream: in_len=5, flush after 2 transfers gives out_valid=0 next cycle and no done. Repeat with rst_n=0 instead: all outputs go to 0 at the edge.
- With VEC_OUT_STREAM_IDX_EN: out_idx reads 0,1,2 alongside 0x55,0x33,0x0F and 0 when idle.
